tile_vga_renderer: RTL

Parametrised VGA timing generator and tile renderer for the snake game display path. It generates sync and data-enable timing from a pixel-rate clock and issues a tile coordinate to the game-state logic. It accepts that logic's tile classification one cycle later and produces a registered pixel colour. Sync and data-enable are delayed in the same pipeline as the colour, so all display outputs stay cycle-aligned. It replaces the fixed 640x480 / 16-pixel-tile controller with generic timing, tile size, colours, sync polarity and a grid-line mode.

---
 rtl/tile_vga_renderer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/tile_vga_renderer.sv
// tile_vga_renderer
// VGA timing generator and tile colour pipeline for the snake display path.
// Counters address a pixel, the tile under it is offered to the game-state
// lookup, and one cycle later the returned tile class is turned into a
// registered colour. Sync and data-enable travel through the same two stages
// so every display output stays cycle-aligned with the colour.
module tile_vga_renderer #(
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int H_DISP    = 640,
   parameter int H_FRONT   = 16,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int V_DISP    = 480,
   parameter int V_FRONT   = 10,
   parameter int TILE_LOG2 = 4,
   parameter int TX_W      = 6,
   parameter int TY_W      = 5,
   parameter int COLOR_W   = 12,
   parameter bit HS_POL    = 1'b0,
   parameter bit VS_POL    = 1'b0,
   parameter logic [COLOR_W-1:0] BG_COLOR    = 12'h000,
   parameter logic [COLOR_W-1:0] HEAD_COLOR  = 12'h0F0,
   parameter logic [COLOR_W-1:0] BODY_COLOR  = 12'h0FF,
   parameter logic [COLOR_W-1:0] WALL_COLOR  = 12'h505,
   parameter logic [COLOR_W-1:0] APPLE_COLOR = 12'hFF0,
   parameter logic [COLOR_W-1:0] GRID_COLOR  = 12'h000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               grid_en,
   input  logic [TX_W-1:0]    apple_x,
   input  logic [TY_W-1:0]    apple_y,
   input  logic [1:0]         tile_type,
   output logic [TX_W-1:0]    tile_x,
   output logic [TY_W-1:0]    tile_y,
   output logic               hsync,
   output logic               vsync,
   output logic               de,
   output logic [COLOR_W-1:0] color_out,
   output logic               frame_start
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
   localparam int H_OFF   = H_SYNC + H_BACK;
   localparam int V_OFF   = V_SYNC + V_BACK;
   localparam int HCW     = $clog2(H_TOTAL);
   localparam int VCW     = $clog2(V_TOTAL);

   typedef enum logic [1:0] {
      TILE_NONE = 2'b00,
      TILE_HEAD = 2'b01,
      TILE_BODY = 2'b10,
      TILE_WALL = 2'b11
   } tileKind_t;

   logic [HCW-1:0]     hCnt_q, hCnt_d;
   logic [VCW-1:0]     vCnt_q, vCnt_d;

   logic [9:0]         pixX, pixY;
   logic               pixActive;
   logic               oxZero, oyZero;
   logic               appleHit;
   logic               hsRaw, vsRaw;
   logic               origin;

   logic               activeS1_q;
   logic               oxZeroS1_q;
   logic               oyZeroS1_q;
   logic               appleHitS1_q;
   logic               hsRawS1_q;
   logic               vsRawS1_q;
   logic               originS1_q;

   tileKind_t          tileKind;
   logic               gridHit;
   logic [COLOR_W-1:0] color_d;

   logic               de_q;
   logic               hsync_q;
   logic               vsync_q;
   logic               frameStart_q;
   logic [COLOR_W-1:0] color_q;

   // Next raster position: horizontal wraps every line, vertical steps at line end
   // and wraps on the very same edge as the last pixel of the frame.
   always_comb begin
      hCnt_d = hCnt_q + HCW'(1);
      vCnt_d = vCnt_q;
      if (hCnt_q == HCW'(H_TOTAL - 1)) begin
         hCnt_d = '0;
         if (vCnt_q == VCW'(V_TOTAL - 1)) begin
            vCnt_d = '0;
         end else begin
            vCnt_d = vCnt_q + VCW'(1);
         end
      end
   end

   // Raster counters; a reset anywhere in the frame restarts from the sync pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hCnt_q <= '0;
         vCnt_q <= '0;
      end else begin
         hCnt_q <= hCnt_d;
         vCnt_q <= vCnt_d;
      end
   end

   // Pixel coordinates relative to the active window; outside the window these
   // wrap to meaningless values, which is harmless because blanking forces BG.
   assign pixX      = 10'(hCnt_q - HCW'(H_OFF));
   assign pixY      = 10'(vCnt_q - VCW'(V_OFF));
   assign pixActive = (hCnt_q >= HCW'(H_OFF)) && (hCnt_q < HCW'(H_OFF + H_DISP)) &&
                      (vCnt_q >= VCW'(V_OFF)) && (vCnt_q < VCW'(V_OFF + V_DISP));

   assign tile_x    = pixX[TILE_LOG2 +: TX_W];
   assign tile_y    = pixY[TILE_LOG2 +: TY_W];
   assign oxZero    = (pixX[TILE_LOG2-1:0] == '0);
   assign oyZero    = (pixY[TILE_LOG2-1:0] == '0);
   assign appleHit  = (tile_x == apple_x) && (tile_y == apple_y);
   assign hsRaw     = (hCnt_q < HCW'(H_SYNC));
   assign vsRaw     = (vCnt_q < VCW'(V_SYNC));
   assign origin    = pixActive && (pixX == '0) && (pixY == '0);

   // Stage 1 holds everything about the pixel that is known locally, while the
   // external lookup spends this same cycle producing the tile class.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         activeS1_q   <= 1'b0;
         oxZeroS1_q   <= 1'b0;
         oyZeroS1_q   <= 1'b0;
         appleHitS1_q <= 1'b0;
         hsRawS1_q    <= 1'b0;
         vsRawS1_q    <= 1'b0;
         originS1_q   <= 1'b0;
      end else begin
         activeS1_q   <= pixActive;
         oxZeroS1_q   <= oxZero;
         oyZeroS1_q   <= oyZero;
         appleHitS1_q <= appleHit;
         hsRawS1_q    <= hsRaw;
         vsRawS1_q    <= vsRaw;
         originS1_q   <= origin;
      end
   end

   assign tileKind = tileKind_t'(tile_type);

   // Colour selection: blanking beats everything, the apple overrides whatever
   // the game state says about its tile, and snake segments get grid lines on
   // their top/left edges (or just the corner dot when grid mode is off).
   always_comb begin
      color_d = BG_COLOR;
      gridHit = grid_en ? (oxZeroS1_q || oyZeroS1_q) : (oxZeroS1_q && oyZeroS1_q);
      if (!activeS1_q) begin
         color_d = BG_COLOR;
      end else if (appleHitS1_q) begin
         color_d = (oxZeroS1_q && oyZeroS1_q) ? GRID_COLOR : APPLE_COLOR;
      end else begin
         case (tileKind)
            TILE_NONE: color_d = BG_COLOR;
            TILE_HEAD: color_d = gridHit ? GRID_COLOR : HEAD_COLOR;
            TILE_BODY: color_d = gridHit ? GRID_COLOR : BODY_COLOR;
            TILE_WALL: color_d = WALL_COLOR;
            default:   color_d = BG_COLOR;
         endcase
      end
   end

   // Stage 2 output registers; sync levels are applied here so polarity is a
   // pure output property and all display signals leave on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         de_q         <= 1'b0;
         color_q      <= BG_COLOR;
         hsync_q      <= ~HS_POL;
         vsync_q      <= ~VS_POL;
         frameStart_q <= 1'b0;
      end else begin
         de_q         <= activeS1_q;
         color_q      <= color_d;
         hsync_q      <= hsRawS1_q ? HS_POL : ~HS_POL;
         vsync_q      <= vsRawS1_q ? VS_POL : ~VS_POL;
         frameStart_q <= originS1_q;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign color_out   = color_q;
   assign frame_start = frameStart_q;

endmodule
